// File: rtl/clipper_reg_arb.sv
// clipper_reg_arb: arbitrates ACD_MM and THI requesters onto one register bus,
// with round-robin on ties, THI-mode MM rejection and an access timeout.
`default_nettype none

module clipper_reg_arb #(
   parameter int                ADDR_W   = 24,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              thi_ena,
   input  logic              mm_req,
   input  logic              mm_wr,
   input  logic [ADDR_W-1:0] mm_addr,
   input  logic [DATA_W-1:0] mm_wdata,
   output logic              mm_ack,
   output logic              mm_err,
   output logic [DATA_W-1:0] mm_rdata,
   input  logic              thi_req,
   input  logic              thi_wr,
   input  logic [ADDR_W-1:0] thi_addr,
   input  logic [DATA_W-1:0] thi_wdata,
   output logic              thi_ack,
   output logic              thi_err,
   output logic [DATA_W-1:0] thi_rdata,
   output logic              reg_cs,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic              reg_ack,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [15:0]         r_cnt;
   logic                r_last_thi;
   logic                r_sel_thi;
   logic [DATA_W-1:0]   r_cap_data;
   logic                r_cap_err;
   logic                r_reg_cs;
   logic                r_reg_wr;
   logic [ADDR_W-1:0]   r_reg_addr;
   logic [DATA_W-1:0]   r_reg_wdata;
   logic                r_mm_ack;
   logic                r_mm_err;
   logic [DATA_W-1:0]   r_mm_rdata;
   logic                r_thi_ack;
   logic                r_thi_err;
   logic [DATA_W-1:0]   r_thi_rdata;

   logic w_thi_elig;
   logic w_mm_elig;
   logic w_mm_rej;
   logic w_grant;
   logic w_pick_thi;
   logic w_timeout;

   // A requester still holds req during its ack cycle, so mask it there.
   assign w_thi_elig = thi_req & ~r_thi_ack;
   assign w_mm_elig  = mm_req & ~thi_ena & ~r_mm_ack;
   assign w_mm_rej   = (r_state == S_IDLE) & mm_req & thi_ena & ~r_mm_ack;
   assign w_grant    = w_thi_elig | w_mm_elig;
   assign w_pick_thi = w_thi_elig & (~w_mm_elig | ~r_last_thi);
   assign w_timeout  = (r_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_grant) w_state_nxt = S_ACCESS;
         S_ACCESS: if (reg_ack || w_timeout) w_state_nxt = S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_last_thi  <= 1'b1;
         r_sel_thi   <= 1'b0;
         r_cap_data  <= '0;
         r_cap_err   <= 1'b0;
         r_reg_cs    <= 1'b0;
         r_reg_wr    <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
         r_mm_ack    <= 1'b0;
         r_mm_err    <= 1'b0;
         r_mm_rdata  <= '0;
         r_thi_ack   <= 1'b0;
         r_thi_err   <= 1'b0;
         r_thi_rdata <= '0;
      end else begin
         r_mm_ack  <= 1'b0;
         r_mm_err  <= 1'b0;
         r_thi_ack <= 1'b0;
         r_thi_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_sel_thi   <= w_pick_thi;
                  r_last_thi  <= w_pick_thi;
                  r_reg_cs    <= 1'b1;
                  r_reg_wr    <= w_pick_thi ? thi_wr    : mm_wr;
                  r_reg_addr  <= w_pick_thi ? thi_addr  : mm_addr;
                  r_reg_wdata <= w_pick_thi ? thi_wdata : mm_wdata;
                  r_cnt       <= '0;
               end
               if (w_mm_rej) begin
                  r_mm_ack   <= 1'b1;
                  r_mm_err   <= 1'b1;
                  r_mm_rdata <= ERR_DATA;
               end
            end
            S_ACCESS: begin
               r_cnt <= r_cnt + 16'd1;
               // A late ack on the timeout cycle still completes normally.
               if (reg_ack) begin
                  r_cap_data <= reg_rdata;
                  r_cap_err  <= 1'b0;
                  r_reg_cs   <= 1'b0;
               end else if (w_timeout) begin
                  r_cap_data <= ERR_DATA;
                  r_cap_err  <= 1'b1;
                  r_reg_cs   <= 1'b0;
               end
            end
            S_RESP: begin
               if (r_sel_thi) begin
                  r_thi_ack   <= 1'b1;
                  r_thi_err   <= r_cap_err;
                  r_thi_rdata <= r_cap_data;
               end else begin
                  r_mm_ack    <= 1'b1;
                  r_mm_err    <= r_cap_err;
                  r_mm_rdata  <= r_cap_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign reg_cs    = r_reg_cs;
   assign reg_wr    = r_reg_wr;
   assign reg_addr  = r_reg_addr;
   assign reg_wdata = r_reg_wdata;
   assign mm_ack    = r_mm_ack;
   assign mm_err    = r_mm_err;
   assign mm_rdata  = r_mm_rdata;
   assign thi_ack   = r_thi_ack;
   assign thi_err   = r_thi_err;
   assign thi_rdata = r_thi_rdata;
   assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/clipper_reg_arb.md
CLIPPER_REG_ARB -- requirements
Module: clipper_reg_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 24, meaning register address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the cycles allowed for reg_ack (legal range 1..65535).
REQ-004 The block SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, meaning read data returned on error.
REQ-005 Port clk  in  1  sole clock; all logic is rising-edge.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port thi_ena  in  1  1 = THI mode; ACD_MM accesses are disabled.
REQ-008 Ports mm_req/mm_wr  in  1 each  ACD_MM request and write flag (0 = read).
REQ-009 Ports mm_addr  in  ADDR_W and mm_wdata  in  DATA_W  ACD_MM address and write data.
REQ-010 Ports mm_ack/mm_err  out  1 each and mm_rdata  out  DATA_W  ACD_MM completion pulse, error flag and read data.
REQ-011 Ports thi_req, thi_wr, thi_addr, thi_wdata, thi_ack, thi_err and thi_rdata SHALL have the same widths and directions as the mm_* ports, for the THI requester.
REQ-012 Ports reg_cs/reg_wr  out  1 each, reg_addr  out  ADDR_W, reg_wdata  out  DATA_W  register bus request.
REQ-013 Ports reg_rdata  in  DATA_W and reg_ack  in  1  register bus response.
REQ-014 Port busy  out  1  a transaction is outstanding on the register bus.

Function
REQ-015 Requester handshake: the requester holds req high with stable wr/addr/wdata until its ack pulse (1 cycle); it may re-assert req on the cycle after ack.
REQ-016 FSM states SHALL be IDLE, ACCESS, RESP; reset state is IDLE.
REQ-017 IDLE, no eligible req: stay in IDLE; all ack/err and reg_cs are 0.
REQ-018 IDLE, eligible req: latch winner id, wr, addr and wdata; next cycle reg_cs=1 with the latched fields; go to ACCESS.
REQ-019 Eligibility: thi_req is always eligible; mm_req is eligible only when thi_ena=0.
REQ-020 mm_req with thi_ena=1 in IDLE: next cycle mm_ack=1, mm_err=1 and mm_rdata=ERR_DATA; reg_cs stays 0 and the FSM stays in IDLE.
REQ-021 If mm_req is rejected and thi_req is eligible in the same IDLE cycle, the THI grant and the MM rejection SHALL both occur.
REQ-022 Both eligible in IDLE: round-robin; the requester not granted last wins; the last-grant pointer resets to THI, so MM wins the first tie.
REQ-023 ACCESS: reg_cs and the fields SHALL be held stable; a 16-bit wait counter increments each cycle from 0.
REQ-024 ACCESS with reg_ack=1: capture reg_rdata; go to RESP; reg_cs=0 on the next cycle.
REQ-025 RESP: pulse the winner's ack for 1 cycle with err=0 and rdata equal to the captured data (write: rdata equal to the captured reg_rdata); return to IDLE.
REQ-026 Latency: req seen in IDLE at cycle 0 gives reg_cs at cycle 1; reg_ack at cycle n gives requester ack at cycle n+2.
REQ-027 Timeout: in ACCESS, when the counter equals TIMEOUT-1 without reg_ack, drop reg_cs and go to RESP with err=1 and rdata=ERR_DATA.
REQ-028 reg_ack arriving in the same cycle as the timeout SHALL win: the transaction completes normally with err=0.
REQ-029 reg_ack seen in IDLE or RESP SHALL be ignored.
REQ-030 thi_ena changing during ACCESS or RESP SHALL NOT abort an in-flight MM transaction; the change affects only later IDLE decisions.
REQ-031 The non-granted requester SHALL see no ack while the other requester is being served.
REQ-032 busy SHALL be 1 in ACCESS and RESP and 0 in IDLE.
REQ-033 mm_ack and thi_ack SHALL never be 1 in the same cycle, except under REQ-021 (rejection plus THI completion cannot coincide because THI completes no earlier than 3 cycles later).

Reset
REQ-034 rst_n=0 SHALL asynchronously force: state IDLE; reg_cs, reg_wr, busy, all ack and err outputs to 0; addr, wdata and rdata outputs to 0; counter 0; last-grant pointer to THI.
REQ-035 Reset during ACCESS SHALL abandon the transaction with no ack; a later reg_ack is ignored under REQ-029.

Verification
REQ-036 thi_ena=0, MM read addr 0x000010, reg_ack at cycle 4 with reg_rdata 0x12345678 -> reg_cs high cycles 1-4; mm_ack=1 at cycle 6 with mm_rdata 0x12345678 and mm_err=0.
REQ-037 thi_ena=1, mm_req=1 -> mm_ack=1 and mm_err=1 at cycle 1, mm_rdata 0xDEADBEEF, reg_cs never asserted.
REQ-038 thi_ena=0, both requesters continuously requesting for 4 transactions -> grant order MM, THI, MM, THI.
REQ-039 TIMEOUT=8, no reg_ack -> reg_cs high for exactly 8 cycles, then requester ack with err=1 and rdata 0xDEADBEEF; a reg_ack 2 cycles later is ignored.
REQ-040 TIMEOUT=8, reg_ack on the 8th ACCESS cycle -> normal completion with err=0.
REQ-041 rst_n low mid-ACCESS -> reg_cs and busy go to 0 immediately; no ack is issued; the next request is served normally.
